func_decoder_q: RTL and testbench

FUNC_DECODER_Q -- requirements
Module: func_decoder_q

---
 rtl/func_decoder_q.sv | 115 +++++++++++
 tb/tb_func_decoder_q.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/func_decoder_q.sv
// Queued one-hot function decoder: codes wait in a FIFO, the head decode sits in a register.
// Optional illegal-code trap (adds port err) is enabled by defining FUNC_DEC_ILLEGAL_TRAP_EN.
module func_decoder_q #(
    parameter int F_W     = 2,
    parameter int DEPTH   = 4,
    parameter int NUM_OPS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [F_W-1:0]           f,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [2**F_W-1:0]        y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
`ifdef FUNC_DEC_ILLEGAL_TRAP_EN
    ,
    output logic                     err
`endif
);

    localparam int YW = 2**F_W;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [F_W:0] NUM_OPS_L = (F_W+1)'(NUM_OPS);
`ifdef FUNC_DEC_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [F_W-1:0] mem_q [DEPTH];
    logic [F_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_inc;
    logic [CW-1:0]  count_q, count_d;
    logic [YW-1:0]  y_q, y_d;
    logic           code_legal, push_try, push, pop;

    function automatic logic [YW-1:0] onehot(input logic [F_W-1:0] c);
        onehot = YW'(1) << c;
    endfunction

    assign in_ready   = (count_q != CW'(DEPTH));
    assign out_valid  = (count_q != '0);
    assign y          = y_q;
    assign count      = count_q;

    assign code_legal = !TRAP_EN || ({1'b0, f} < NUM_OPS_L);
    assign push_try   = in_valid && in_ready;
    assign push       = push_try && code_legal;
    assign pop        = out_valid && out_ready;

    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_inc = rd_ptr_q + PW'(1);
        y_d        = y_q;

        if (push) begin
            mem_d[wr_ptr_q] = f;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_inc;
        end
        count_d = count_q + CW'(push) - CW'(pop);

        // y tracks the head: reload only when the head changes (pop, or push into empty)
        if (pop) begin
            if (count_q == CW'(1)) begin
                y_d = push ? onehot(f) : '0;
            end else begin
                y_d = onehot(mem_q[rd_ptr_inc]);
            end
        end else if (push && (count_q == '0)) begin
            y_d = onehot(f);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            y_q      <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            y_q      <= y_d;
        end
    end

`ifdef FUNC_DEC_ILLEGAL_TRAP_EN
    logic err_q, err_d;

    assign err_d = push_try && !code_legal;
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_func_decoder_q.sv
// Scoreboard bench for func_decoder_q: a queue-based reference model tracks accepted codes,
// a negedge monitor compares every DUT output against it.
module tb_func_decoder_q;

    localparam int F_W   = 2;
    localparam int DEPTH = 4;
    localparam int YW    = 4;
`ifdef FUNC_DEC_ILLEGAL_TRAP_EN
    localparam int NOPS  = 3;
`else
    localparam int NOPS  = 4;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [F_W-1:0]         f;
    logic                   in_valid;
    logic                   in_ready;
    logic [YW-1:0]          y;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] count;
`ifdef FUNC_DEC_ILLEGAL_TRAP_EN
    logic                   err;
    bit                     exp_err = 1'b0;
`endif

    int errors  = 0;
    int checks  = 0;
    int max_cnt = 0;
    int fq[$];
    bit m_acc, m_pop, m_legal;

    func_decoder_q #(
        .F_W     (F_W),
        .DEPTH   (DEPTH),
        .NUM_OPS (NOPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .f         (f),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
`ifdef FUNC_DEC_ILLEGAL_TRAP_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of accepted codes, updated on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
`ifdef FUNC_DEC_ILLEGAL_TRAP_EN
            exp_err = 1'b0;
`endif
        end else begin
            m_acc   = in_valid && (fq.size() != DEPTH);
            m_pop   = out_ready && (fq.size() != 0);
            m_legal = (int'(f) < NOPS);
            if (m_pop) void'(fq.pop_front());
            if (m_acc && m_legal) fq.push_back(int'(f));
`ifdef FUNC_DEC_ILLEGAL_TRAP_EN
            exp_err = m_acc && !m_legal;
`endif
        end
    end

    // Monitor: compare outputs away from the active edge.
    always @(negedge clk) begin
        chk("count", 32'(count), 32'(fq.size()));
        chk("in_ready", 32'(in_ready), 32'(fq.size() != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(fq.size() != 0));
        chk("y", 32'(y), (fq.size() != 0) ? (32'd1 << fq[0]) : 32'd0);
`ifdef FUNC_DEC_ILLEGAL_TRAP_EN
        chk("err", 32'(err), 32'(exp_err));
`endif
        if (int'(count) > max_cnt) max_cnt = int'(count);
    end

    task automatic step(input bit v, input int fv, input bit ordy);
        in_valid  = v;
        f         = F_W'(fv);
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; f = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_y", 32'(y), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // single decode
        step(1, 2, 0);
        chk("single_y", 32'(y), 32'b0100);
        chk("single_count", 32'(count), 32'd1);
        step(0, 0, 1);
        chk("single_pop_y", 32'(y), 32'd0);
        chk("single_pop_valid", 32'(out_valid), 32'd0);

        // fill to full, fifth push ignored, then drain
        for (int i = 0; i < 5; i++) step(1, i % 4, 0);
`ifndef FUNC_DEC_ILLEGAL_TRAP_EN
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_y", 32'(y), 32'd1 << i);
            step(0, 0, 1);
        end
`else
        for (int i = 0; i < 4; i++) step(0, 0, 1);
`endif

        // simultaneous push and pop at count 1
        step(1, 1, 0);
        step(1, 3, 1);
`ifndef FUNC_DEC_ILLEGAL_TRAP_EN
        chk("pushpop_count", 32'(count), 32'd1);
        chk("pushpop_y", 32'(y), 32'b1000);
`endif
        step(0, 0, 1);

        // continuous streaming across pointer wrap
        max_cnt = 0;
        for (int i = 0; i < 10; i++) step(1, i % 4, 1);
        step(0, 0, 1);
        chk("wrap_max_count_le1", 32'(max_cnt <= 1), 32'd1);

        // reset mid-operation, then push in the first free cycle
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        chk("pre_rst_count", 32'(count), 32'd3);
        rst = 1'b1;
        step(1, 2, 1);
        rst = 1'b0;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_y", 32'(y), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        step(1, 1, 0);
        chk("post_rst_y", 32'(y), 32'b0010);
        step(0, 0, 1);

`ifdef FUNC_DEC_ILLEGAL_TRAP_EN
        step(1, 3, 0);
        chk("trap_err", 32'(err), 32'd1);
        chk("trap_count", 32'(count), 32'd0);
        step(1, 2, 0);
        chk("legal_err", 32'(err), 32'd0);
        chk("legal_count", 32'(count), 32'd1);
        step(0, 0, 1);
`endif

        // randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
